cam_soc_onchip_mem_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port 1024x32 on-chip RAM between two requesters. Requester 0 is the camera frame writer; requester 1 is the encryption engine reader/writer. The block sits between both masters and the RAM's s1-style slave port. It provides round-robin arbitration with bounded grant hold, waitrequest back-pressure and pipelined readdatavalid.

---
 rtl/cam_soc_mem_pkg.sv | 15 +
 rtl/cam_soc_rr_grant.sv | 39 +++
 rtl/cam_soc_onchip_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_cam_soc_onchip_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_soc_mem_pkg.sv
// Shared definitions for the camera SoC on-chip RAM arbiter.
package cam_soc_mem_pkg;

    localparam int unsigned MEM_ADDR_W     = 10;
    localparam int unsigned MEM_DATA_W     = 32;
    localparam int unsigned MEM_BE_W       = 4;
    localparam int unsigned MEM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1
    } arb_state_t;

endpackage

// File: rtl/cam_soc_rr_grant.sv
// Two-way round-robin grant with bounded ownership hold.
module cam_soc_rr_grant
    import cam_soc_mem_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic              reset,
    input  logic [1:0]        req,
    input  arb_state_t        state,
    input  logic [HOLD_W-1:0] hold_cnt,
    input  logic              last_grant,
    output logic [1:0]        grant
);

    logic keep;

    assign keep = (hold_cnt < HOLD_W'(MAX_HOLD));

    // Owner keeps the RAM under contention until its hold budget runs out.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
                2'b11: begin
                    case (state)
                        ARB_OWN0: grant = keep ? 2'b01 : 2'b10;
                        ARB_OWN1: grant = keep ? 2'b10 : 2'b01;
                        default:  grant = last_grant ? 2'b01 : 2'b10;
                    endcase
                end
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/cam_soc_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the camera writer (rq0)
// and the encryption engine (rq1), with a one-cycle read pipeline.
module cam_soc_onchip_mem_arbiter
    import cam_soc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rq0_address,
    input  logic                rq0_read,
    input  logic                rq0_write,
    input  logic [DATA_W-1:0]   rq0_writedata,
    input  logic [DATA_W/8-1:0] rq0_byteenable,
    output logic                rq0_waitrequest,
    output logic [DATA_W-1:0]   rq0_readdata,
    output logic                rq0_readdatavalid,
    input  logic [ADDR_W-1:0]   rq1_address,
    input  logic                rq1_read,
    input  logic                rq1_write,
    input  logic [DATA_W-1:0]   rq1_writedata,
    input  logic [DATA_W/8-1:0] rq1_byteenable,
    output logic                rq1_waitrequest,
    output logic [DATA_W-1:0]   rq1_readdata,
    output logic                rq1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int unsigned HOLD_W = 4;

    arb_state_t        state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              last_grant, last_grant_n;
    logic              rd_pend, rd_pend_n;
    logic              rd_id, rd_id_n;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic [HOLD_W-1:0] hold_inc;

    assign req = {rq1_read | rq1_write, rq0_read | rq0_write};

    cam_soc_rr_grant #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_grant (
        .reset      (reset),
        .req        (req),
        .state      (state),
        .hold_cnt   (hold_cnt),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            hold_cnt   <= '0;
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            last_grant <= last_grant_n;
            rd_pend    <= rd_pend_n;
            rd_id      <= rd_id_n;
        end
    end

    assign hold_inc = (hold_cnt >= HOLD_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + HOLD_W'(1);

    // Ownership tracking; a read+write beat counts as a write only.
    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        last_grant_n = last_grant;
        rd_pend_n    = 1'b0;
        rd_id_n      = rd_id;
        if (grant[0]) begin
            state_n      = ARB_OWN0;
            last_grant_n = 1'b0;
            hold_cnt_n   = (state == ARB_OWN0) ? hold_inc : HOLD_W'(1);
            rd_pend_n    = rq0_read & ~rq0_write;
            rd_id_n      = 1'b0;
        end else if (grant[1]) begin
            state_n      = ARB_OWN1;
            last_grant_n = 1'b1;
            hold_cnt_n   = (state == ARB_OWN1) ? hold_inc : HOLD_W'(1);
            rd_pend_n    = rq1_read & ~rq1_write;
            rd_id_n      = 1'b1;
        end else if (req == 2'b00) begin
            state_n    = ARB_IDLE;
            hold_cnt_n = '0;
        end
    end

    // RAM mux and requester responses; reset drops any pending read return.
    always_comb begin
        mem_address       = grant[1] ? rq1_address    : rq0_address;
        mem_writedata     = grant[1] ? rq1_writedata  : rq0_writedata;
        mem_byteenable    = grant[1] ? rq1_byteenable : rq0_byteenable;
        mem_chipselect    = |grant;
        mem_write         = (grant[0] & rq0_write) | (grant[1] & rq1_write);
        mem_clken         = ~reset;
        rq0_waitrequest   = req[0] & ~grant[0];
        rq1_waitrequest   = req[1] & ~grant[1];
        rq0_readdatavalid = rd_pend & ~reset & ~rd_id;
        rq1_readdatavalid = rd_pend & ~reset & rd_id;
        rq0_readdata      = rq0_readdatavalid ? mem_readdata : '0;
        rq1_readdata      = rq1_readdatavalid ? mem_readdata : '0;
    end

endmodule

// File: tb/tb_cam_soc_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural 1024x32 RAM.
module tb_cam_soc_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rq0_address, rq1_address;
    logic        rq0_read, rq0_write, rq1_read, rq1_write;
    logic [31:0] rq0_writedata, rq1_writedata;
    logic [3:0]  rq0_byteenable, rq1_byteenable;
    logic        rq0_waitrequest, rq1_waitrequest;
    logic [31:0] rq0_readdata, rq1_readdata;
    logic        rq0_readdatavalid, rq1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    logic [31:0] ram [1024];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_soc_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .rq0_address(rq0_address), .rq0_read(rq0_read), .rq0_write(rq0_write),
        .rq0_writedata(rq0_writedata), .rq0_byteenable(rq0_byteenable),
        .rq0_waitrequest(rq0_waitrequest), .rq0_readdata(rq0_readdata),
        .rq0_readdatavalid(rq0_readdatavalid),
        .rq1_address(rq1_address), .rq1_read(rq1_read), .rq1_write(rq1_write),
        .rq1_writedata(rq1_writedata), .rq1_byteenable(rq1_byteenable),
        .rq1_waitrequest(rq1_waitrequest), .rq1_readdata(rq1_readdata),
        .rq1_readdatavalid(rq1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // Synchronous-read RAM; two words are seeded while reset is high.
    always @(posedge clk) begin
        if (reset) begin
            ram[10] <= 32'h1010_0010;
            ram[20] <= 32'h2020_0020;
        end else if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_all();
        rq0_read = 0; rq0_write = 0; rq1_read = 0; rq1_write = 0;
    endtask

    logic exp_g2 [10];
    logic exp_g6 [6];

    initial begin
        exp_g2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        exp_g6 = '{0, 0, 0, 0, 1, 1};
        reset = 1;
        idle_all();
        rq0_address = 0; rq1_address = 0;
        rq0_writedata = 0; rq1_writedata = 0;
        rq0_byteenable = 4'hF; rq1_byteenable = 4'hF;

        // Reset: grants suppressed, requester sees waitrequest
        cyc(); cyc();
        rq0_read = 1; rq0_address = 10'd3;
        mid();
        chk("rst_wait0", 32'(rq0_waitrequest), 32'd1);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd0);
        chk("rst_mwrite", 32'(mem_write), 32'd0);
        chk("rst_valid0", 32'(rq0_readdatavalid), 32'd0);
        chk("rst_valid1", 32'(rq1_readdatavalid), 32'd0);

        // Contention: 4 beats each, readdatavalid tagged to previous winner
        cyc();
        reset = 0;
        rq0_read = 1; rq0_address = 10'd10;
        rq1_read = 1; rq1_address = 10'd20;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk($sformatf("cont_addr%0d", i), 32'(mem_address), exp_g2[i] ? 32'd20 : 32'd10);
            chk($sformatf("cont_wait0_%0d", i), 32'(rq0_waitrequest), 32'(exp_g2[i]));
            chk($sformatf("cont_wait1_%0d", i), 32'(rq1_waitrequest), 32'(!exp_g2[i]));
            if (i > 0) begin
                chk($sformatf("cont_v0_%0d", i), 32'(rq0_readdatavalid), 32'(!exp_g2[i-1]));
                chk($sformatf("cont_v1_%0d", i), 32'(rq1_readdatavalid), 32'(exp_g2[i-1]));
                if (exp_g2[i-1]) chk($sformatf("cont_d1_%0d", i), rq1_readdata, 32'h2020_0020);
                else             chk($sformatf("cont_d0_%0d", i), rq0_readdata, 32'h1010_0010);
            end
            if (i < 9) cyc();
        end
        cyc(); idle_all();
        mid();
        chk("cont_last_v0", 32'(rq0_readdatavalid), 32'd1);
        chk("cont_last_d0", rq0_readdata, 32'h1010_0010);
        chk("cont_idle_cs", 32'(mem_chipselect), 32'd0);

        // Single write then read on rq0
        cyc();
        rq0_write = 1; rq0_address = 10'd5; rq0_writedata = 32'hDEAD_BEEF; rq0_byteenable = 4'hF;
        mid();
        chk("wr_wait0", 32'(rq0_waitrequest), 32'd0);
        chk("wr_mwrite", 32'(mem_write), 32'd1);
        chk("wr_addr", 32'(mem_address), 32'd5);
        chk("wr_data", mem_writedata, 32'hDEAD_BEEF);
        chk("wr_clken", 32'(mem_clken), 32'd1);
        cyc();
        rq0_write = 0; rq0_read = 1;
        mid();
        chk("rd_wait0", 32'(rq0_waitrequest), 32'd0);
        chk("rd_mwrite", 32'(mem_write), 32'd0);
        chk("rd_novalid_after_wr", 32'(rq0_readdatavalid), 32'd0);
        cyc(); idle_all();
        mid();
        chk("rd_valid0", 32'(rq0_readdatavalid), 32'd1);
        chk("rd_data0", rq0_readdata, 32'hDEAD_BEEF);
        chk("rd_valid1", 32'(rq1_readdatavalid), 32'd0);

        // Byte lanes on top address via rq1
        cyc();
        rq1_write = 1; rq1_address = 10'd1023; rq1_writedata = 32'hAAAA_AAAA; rq1_byteenable = 4'hF;
        mid();
        chk("be_wait1", 32'(rq1_waitrequest), 32'd0);
        cyc();
        rq1_writedata = 32'h1122_3344; rq1_byteenable = 4'h3;
        mid();
        chk("be_mbe", 32'(mem_byteenable), 32'h3);
        chk("be_addr", 32'(mem_address), 32'd1023);
        cyc();
        rq1_write = 0; rq1_read = 1;
        cyc(); idle_all();
        mid();
        chk("be_valid1", 32'(rq1_readdatavalid), 32'd1);
        chk("be_data1", rq1_readdata, 32'hAAAA_3344);
        chk("be_valid0", 32'(rq0_readdatavalid), 32'd0);

        // Read+write collision is a write with no return
        cyc();
        rq0_read = 1; rq0_write = 1; rq0_address = 10'd7;
        rq0_writedata = 32'h5A5A_5A5A; rq0_byteenable = 4'hF;
        mid();
        chk("col_mwrite", 32'(mem_write), 32'd1);
        chk("col_wait0", 32'(rq0_waitrequest), 32'd0);
        cyc(); idle_all();
        mid();
        chk("col_novalid", 32'(rq0_readdatavalid), 32'd0);
        cyc();
        rq0_read = 1;
        cyc(); idle_all();
        mid();
        chk("col_valid0", 32'(rq0_readdatavalid), 32'd1);
        chk("col_data0", rq0_readdata, 32'h5A5A_5A5A);

        // Idle gap: rq1 two beats, idle, then contention restarts on rq0
        cyc();
        rq1_read = 1; rq1_address = 10'd20;
        mid();
        chk("gap_wait1_a", 32'(rq1_waitrequest), 32'd0);
        cyc();
        mid();
        chk("gap_wait1_b", 32'(rq1_waitrequest), 32'd0);
        cyc(); idle_all();
        mid();
        chk("gap_idle_cs", 32'(mem_chipselect), 32'd0);
        chk("gap_idle_v1", 32'(rq1_readdatavalid), 32'd1);
        cyc();
        rq0_read = 1; rq0_address = 10'd10;
        rq1_read = 1; rq1_address = 10'd20;
        for (int i = 0; i < 6; i++) begin
            mid();
            chk($sformatf("gap_addr%0d", i), 32'(mem_address), exp_g6[i] ? 32'd20 : 32'd10);
            chk($sformatf("gap_wait0_%0d", i), 32'(rq0_waitrequest), 32'(exp_g6[i]));
            if (i < 5) cyc();
        end
        cyc(); idle_all();
        cyc();

        // Reset mid-read drops the pending return
        rq0_read = 1; rq0_address = 10'd10;
        mid();
        chk("rmr_wait0", 32'(rq0_waitrequest), 32'd0);
        cyc();
        reset = 1; idle_all();
        mid();
        chk("rmr_valid0", 32'(rq0_readdatavalid), 32'd0);
        chk("rmr_cs", 32'(mem_chipselect), 32'd0);
        cyc();
        rq0_read = 1; rq1_read = 1; rq1_address = 10'd20;
        mid();
        chk("rmr_rst_wait0", 32'(rq0_waitrequest), 32'd1);
        chk("rmr_rst_wait1", 32'(rq1_waitrequest), 32'd1);
        chk("rmr_rst_valid0", 32'(rq0_readdatavalid), 32'd0);
        cyc();
        reset = 0;
        mid();
        chk("post_rst_wait0", 32'(rq0_waitrequest), 32'd0);
        chk("post_rst_wait1", 32'(rq1_waitrequest), 32'd1);
        chk("post_rst_addr", 32'(mem_address), 32'd10);
        chk("post_rst_valid0", 32'(rq0_readdatavalid), 32'd0);
        cyc(); idle_all();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
